word_ram: RTL and testbench
===========================

Name: word_ram

Overview:
Parametrised synchronous word memory: DEPTH words × WIDTH bits, one write port and one read port, all on one clock. It is the next generation of the team's 4-word latch-based bit-slice memory, generalised in width and depth. It adds a registered read with a valid strobe, write-first bypass, and a hardware clear engine that zeroes every word after reset or on request. It sits behind the register/data-path logic as general scratch storage.

Parameters:
WIDTH, 4, bits per word (≥1)
DEPTH, 4, number of words (≥2, need not be a power of two)
AW, $clog2(DEPTH), address width; derived localparam, not overridable

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
wr_en  in  1  write request
wr_addr  in  AW  write address
wr_data  in  WIDTH  write data
rd_en  in  1  read request
rd_addr  in  AW  read address
rd_data  out  WIDTH  read data, registered
rd_valid  out  1  one-cycle strobe: rd_data is valid
clr  in  1  request a full zero sweep
busy  out  1  clear sweep in progress; port requests are dropped

Behaviour:
- Reset (rst_n low, asynchronous): rd_data=0, rd_valid=0, busy=1, state=CLEAR, sweep pointer=0. Storage contents are not reset directly.
- Reset release: the CLEAR state writes 0 to word[ptr] each cycle, with ptr counting 0..DEPTH-1.
  - After the write to DEPTH-1, the next state is IDLE and busy drops.
  - busy is therefore high for exactly DEPTH cycles after the first rising edge with rst_n high.
- IDLE, clr=1: the next state is CLEAR, ptr=0, and busy=1 from the next cycle.
  - Port requests in that same cycle are still serviced.
  - clr while already in CLEAR is ignored; the sweep does not restart.
- CLEAR: wr_en and rd_en are ignored. No write occurs and rd_valid stays 0. There is no queueing.
- Write (IDLE, wr_en=1, wr_addr<DEPTH): word[wr_addr] ← wr_data at the clock edge.
- Read (IDLE, rd_en=1): one-cycle latency. rd_data and rd_valid are registered at the edge after the request. rd_valid is high for one cycle per accepted read.
  - rd_addr≥DEPTH: rd_data=0 and rd_valid=1.
  - wr_addr≥DEPTH: the write is silently dropped.
- Read and write same cycle, same address: write-first. rd_data returns the new wr_data.
  - Different addresses: both complete independently.
- rd_data holds its last value when rd_valid=0. It is not cleared by a sweep, only by reset.
- Reset asserted mid-sweep or mid-read aborts immediately to the reset values. The sweep restarts from ptr=0.
- All arithmetic on ptr is AW-bit unsigned. The terminal compare is ptr==DEPTH-1, with no wrap-around past DEPTH-1.

Decomposition:
- Shared package mem_pkg holds the state enum ram_state_t {IDLE, CLEAR}.
- One sub-module: ram_clear_fsm (state register, sweep pointer, busy, clr handling). It outputs clr_we and clr_addr, which word_ram muxes onto the write port.
- The storage array, bypass and read register stay in word_ram.

Test Plan:
- Reset release, WIDTH=4/DEPTH=4 -> busy high exactly 4 cycles; then reads of addr 0..3 return 0x0 with rd_valid one cycle after each rd_en.
- Write 0xA to addr 2, then rd_en addr 2 the next cycle -> rd_data=0xA, rd_valid=1 one cycle after rd_en.
- Same-cycle wr_en addr1=0x5 and rd_en addr1 (old value 0x3) -> rd_data=0x5 (write-first).
- Fill 0xF everywhere, pulse clr -> busy 4 cycles; wr_en/rd_en during busy produce no write and rd_valid=0; afterwards all words read 0x0.
- Assert rst_n low at sweep ptr=2 -> outputs return to reset values asynchronously; after release busy lasts the full 4 cycles again.
- DEPTH=5 (AW=3): write 0x7 to addr 6 -> no word changes; read addr 6 -> rd_data=0, rd_valid=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the word_ram scratch memory.
// The clear engine is either serving port requests or sweeping zeros.
package mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_t;

endpackage

// File: rtl/ram_clear_fsm.sv
// Zero-sweep engine for word_ram: owns the state, the sweep pointer and busy.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ports serviced; clr starts a sweep from word 0
//   CLEAR | writes 0 to word[ptr] each cycle; ports ignored; clr ignored
module ram_clear_fsm
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ram_state_t    state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          // Terminal compare only; the pointer never runs past the last word.
          if (ptr_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/word_ram.sv
// DEPTH x WIDTH scratch memory: one write port, one registered read port with
// valid strobe, write-first bypass, and a hardware zero sweep after reset / on clr.
module word_ram
  import mem_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             clr,
  output logic             busy
);

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  ram_clear_fsm #(.DEPTH(DEPTH), .AW(AW)) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Range checks only matter when DEPTH leaves unused address codes.
  if ((1 << AW) == DEPTH) begin : g_full_range
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_part_range
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  end

  assign mem_we    = busy ? clr_we   : (wr_en && wr_in_range);
  assign mem_waddr = busy ? clr_addr : wr_addr;
  assign mem_wdata = busy ? '0       : wr_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (!busy && rd_en) begin
      rd_valid_d = 1'b1;
      if (!rd_in_range)
        rd_data_d = '0;
      else if (wr_en && (wr_addr == rd_addr))
        rd_data_d = wr_data;
      else
        rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_word_ram.sv
// Bench for word_ram: a DEPTH=4 and a DEPTH=5 instance share one stimulus stream
// and are checked every cycle against an abstract memory model.
module tb_word_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr = 1'b0;
  logic [2:0] wr_addr = '0, rd_addr = '0;
  logic [3:0] wr_data = '0;
  logic [3:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1, busy0, busy1;

  always #5 clk = ~clk;

  word_ram #(.WIDTH(4), .DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr[1:0]), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .clr(clr), .busy(busy0)
  );

  word_ram #(.WIDTH(4), .DEPTH(5)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .clr(clr), .busy(busy1)
  );

  int compared = 0;
  int mismatched = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: memory contents, words left to sweep, and the last read result.
  int         depth [2] = '{4, 5};
  logic [3:0] m_mem [2][8];
  int         m_left [2];
  logic [3:0] m_data [2];
  logic       m_valid [2];

  task automatic model_step(input int k);
    int wa, ra;
    wa = (k == 0) ? int'(wr_addr[1:0]) : int'(wr_addr);
    ra = (k == 0) ? int'(rd_addr[1:0]) : int'(rd_addr);
    if (m_left[k] > 0) begin
      m_mem[k][depth[k] - m_left[k]] = 4'h0;
      m_left[k]--;
      m_valid[k] = 1'b0;
    end else begin
      m_valid[k] = rd_en;
      if (rd_en) begin
        if (ra >= depth[k])                 m_data[k] = 4'h0;
        else if (wr_en && wa == ra)         m_data[k] = wr_data;
        else                                m_data[k] = m_mem[k][ra];
      end
      if (wr_en && wa < depth[k]) m_mem[k][wa] = wr_data;
      if (clr) m_left[k] = depth[k];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_left[k]  = depth[k];
        m_data[k]  = 4'h0;
        m_valid[k] = 1'b0;
      end else begin
        model_step(k);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rd_data0",  rd_data0,  m_data[0]);
      chk("rd_valid0", rd_valid0, m_valid[0]);
      chk("busy0",     busy0,     m_left[0] > 0);
      chk("rd_data1",  rd_data1,  m_data[1]);
      chk("rd_valid1", rd_valid1, m_valid[1]);
      chk("busy1",     busy1,     m_left[1] > 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  // Releases reset mid-cycle and counts sampled cycles with busy high.
  task automatic release_and_count(output int n0, output int n1);
    #2 rst_n = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      n0 += int'(busy0);
      n1 += int'(busy1);
      tick();
    end
  endtask

  int n0, n1;

  initial begin
    tick();
    chk_on = 1'b1;
    tick();
    chk("reset_busy0", busy0, 1);
    chk("reset_rd_data0", rd_data0, 0);

    release_and_count(n0, n1);
    chk("busy_len_d4", n0, 4);
    chk("busy_len_d5", n1, 5);

    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = 3'(i);
      tick();
      chk("post_reset_valid", rd_valid0, 1);
      chk("post_reset_data", rd_data0, 0);
    end
    idle_inputs();

    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hA;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 3'd2;
    tick();
    chk("rd_after_wr_data", rd_data0, 4'hA);
    chk("rd_after_wr_valid", rd_valid0, 1);
    idle_inputs();
    tick();
    chk("rd_valid_one_cycle", rd_valid0, 0);

    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'h3;
    tick();
    wr_data = 4'h5; rd_en = 1'b1; rd_addr = 3'd1;
    tick();
    chk("write_first", rd_data0, 4'h5);
    idle_inputs();

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'hF;
      tick();
    end
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy", busy0, 1);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 3)); wr_data = 4'hF;
      rd_en = 1'b1; rd_addr = 3'($urandom_range(0, 3));
      tick();
      chk("busy_no_valid", rd_valid0, 0);
    end
    idle_inputs();
    tick();
    chk("sweep_done", busy0, 0);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = 3'(i);
      tick();
      chk("post_clr_data", rd_data0, 0);
    end
    idle_inputs();

    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'h9;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 3'd3;
    tick();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    chk("hold_through_sweep", rd_data0, 4'h9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy0, 1);
    chk("async_rst_valid", rd_valid0, 0);
    chk("async_rst_data", rd_data0, 0);
    tick();
    release_and_count(n0, n1);
    chk("busy_len_after_abort", n0, 4);

    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 4'h7;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 3'd6;
    tick();
    chk("oor_read_data", rd_data1, 0);
    chk("oor_read_valid", rd_valid1, 1);
    for (int i = 0; i < 5; i++) begin
      rd_addr = 3'(i);
      tick();
      chk("oor_write_dropped", rd_data1, 0);
    end
    idle_inputs();

    for (int c = 0; c < 3000; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      clr     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
      end
      tick();
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
